fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side controller for the synchronous FIFO built around the dual-port RAM. It takes the writer's pointer, drives the RAM read address, and captures the RAM's combinational read data. It presents the entries in order on a valid/ready stream through a 2-entry output buffer, so `m_ready` never reaches `rd_addr` combinationally and throughput stays at one word per cycle. It returns `rd_ptr` to the writer for full detection.

## Interface
- `DWIDTH`, 64, data width; matches the RAM.
- `DEPTH`, 16, RAM depth; power of 2, ≥2. `AW = $clog2(DEPTH)`.
- `clk` in 1: single clock, shared with the RAM write side.
- `rst_n` in 1: synchronous, active-low reset.
- `wr_ptr` in AW+1: writer pointer, binary, MSB is the wrap bit.
- `rd_ptr` out AW+1: read pointer, binary, MSB is the wrap bit.
- `rd_addr` out AW: RAM read address, equal to `rd_ptr[AW-1:0]`.
- `rd_data` in DWIDTH: RAM read data, combinational from `rd_addr`.
- `m_data` out DWIDTH: head-of-stream data.
- `m_valid` out 1: head valid.
- `m_ready` in 1: consumer accepts the head.
- `rd_level` out AW+2: only with `FIFO_RD_LEVEL_EN`.

## Operation
- `avail = (wr_ptr != rd_ptr)`.
- `fetch = avail && (state != S_TWO)`. `fetch` depends only on registers and `wr_ptr`, never on `m_ready`.
- `pop = m_valid && m_ready`.
- On `fetch`:
  - `rd_data` is captured into the buffer.
  - `rd_ptr <= rd_ptr + 1`, modulo 2^(AW+1).
- Buffer state machine:
  - `S_EMPTY`: `fetch` → `S_ONE` (write head); otherwise stay.
  - `S_ONE`:
    - `fetch && !pop` → `S_TWO` (write tail).
    - `fetch && pop` → `S_ONE` (head takes the new word).
    - `!fetch && pop` → `S_EMPTY`.
    - Otherwise stay.
  - `S_TWO`: `pop` → `S_ONE` (tail moves to head); otherwise stay. No fetch occurs in this state.
- `m_valid = (state != S_EMPTY)`; `m_data` is always the head register.
- Ordering is strict FIFO.
- The stream holds `m_data` stable while `m_valid && !m_ready`.
- Words in the buffer are already released from the RAM. The writer computes full as `wr_ptr - rd_ptr == DEPTH`, so total capacity is DEPTH+2.
- Empty RAM (`wr_ptr == rd_ptr`): no fetch, `rd_ptr` holds; the buffer still drains.
- Pointer wrap: `rd_ptr` rolls from 2^(AW+1)-1 to 0. The MSB distinguishes full from empty at the writer.
- `wr_ptr` moving backwards, or exceeding `rd_ptr` by more than DEPTH, is illegal; behaviour is undefined.

## Timing
- Reset (`rst_n` = 0 sampled at a `clk` edge):
  - `rd_ptr` = 0, state = `S_EMPTY`.
  - `m_valid` = 0, `m_data` = 0, tail register = 0.
  - `rd_level` = 0.
- Reset mid-operation discards buffered words. The writer must be reset on the same edge.
- Latency: a `wr_ptr` increment seen in cycle N produces `m_valid` = 1 after edge N+1 (one cycle).
- `rd_ptr` updates on the same edge that captures the word.
- Throughput: one word per cycle while `m_ready` is held high and `avail`, with steady state `S_ONE`.
- The `m_ready` → output path is registered only. No combinational path exists from `m_ready` to `rd_addr` or `rd_ptr`.

## Configuration
- `FIFO_RD_LEVEL_EN` defined:
  - Adds output `rd_level = (wr_ptr - rd_ptr) + buffer occupancy`, range 0..DEPTH+2.
  - Subtraction is modulo 2^(AW+1), zero-extended before the add.
  - Combinational from registers and `wr_ptr`.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Package `fifo_rd_pkg`:
  - State enum `rd_buf_state_e` (`S_EMPTY`, `S_ONE`, `S_TWO`).
  - Pointer-width localparam/function derived from `DEPTH`.
- Sub-module `rd_out_buf`: the 2-entry buffer and its state machine. Inputs are `push`/`push_data`/`pop`; outputs are `full`, `m_valid`, `m_data`, and the occupancy count.
- Top level holds the pointer logic and the `fetch` decision. The RAM is instantiated outside, alongside the writer.

## Test plan
All scenarios use `DWIDTH` = 8, `DEPTH` = 4.
- Reset, then `wr_ptr` = 0 for 5 cycles → `m_valid` = 0, `rd_ptr` = 0, `m_data` = 0.
- RAM preloaded with 0xA0..0xA3, `wr_ptr` steps 0→4 in one cycle, `m_ready` = 1 → `m_data` shows 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles starting 1 cycle later; then `rd_ptr` = 4 and `m_valid` = 0.
- `m_ready` = 0, `wr_ptr` = 4 → after 2 fetches, state `S_TWO` and `rd_ptr` = 2. `m_data` holds 0xA0 stable and `rd_level` = 4.
- Then `m_ready` toggles 1/0 → order 0xA0..0xA3 preserved, no duplicates or drops.
- Wrap: run 20 words through with data = index → output sequence 0..19 intact, `rd_ptr` = 20 mod 8 = 4.
- Assert `rst_n` = 0 while in `S_TWO` → next cycle `m_valid` = 0, `rd_ptr` = 0, `rd_level` = 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream controller.
// The optional FIFO_RD_LEVEL_EN build adds a level output at the top level.
package fifo_rd_pkg;

  // Fixed encodings keep the state values stable for older netlists and scripts.
  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_ONE_ENC   = 2'd1;
  localparam logic [1:0] ST_TWO_ENC   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY_ENC,
    S_ONE   = ST_ONE_ENC,
    S_TWO   = ST_TWO_ENC
  } rd_buf_state_e;

  localparam int OCC_W = 2;

  // Pointer width carries one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rd_out_buf.sv
// Two-entry output skid buffer that decouples m_ready from the RAM read address.
//   state   | meaning
//   S_EMPTY | no word held, m_valid low
//   S_ONE   | head holds the next word
//   S_TWO   | head and tail both hold words, no further push accepted
module rd_out_buf
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic [OCC_W-1:0]  count
);

  rd_buf_state_e     state;
  logic [DWIDTH-1:0] head_q;
  logic [DWIDTH-1:0] tail_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            head_q <= push_data;
            state  <= S_ONE;
          end
        end
        S_ONE: begin
          // A simultaneous push and pop refills the head directly, keeping full rate.
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q <= push_data;
            state  <= S_TWO;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            head_q <= tail_q;
            state  <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_comb begin
    count = '0;
    case (state)
      S_ONE:   count = 2'd1;
      S_TWO:   count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  assign full    = (state == S_TWO);
  assign m_valid = (state != S_EMPTY);
  assign m_data  = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side controller of the synchronous FIFO: walks rd_ptr over the RAM and streams words out.
// Defining FIFO_RD_LEVEL_EN adds the rd_level output (RAM words plus buffered words).
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW:0]       wr_ptr,
  output logic [AW:0]       rd_ptr,
  output logic [AW-1:0]     rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [AW+1:0]     rd_level
`endif
);

  logic             avail;
  logic             fetch;
  logic             pop;
  logic             buf_full;
  logic [OCC_W-1:0] occ;

  // fetch depends only on registers and wr_ptr, so m_ready never reaches rd_addr.
  assign avail   = (wr_ptr != rd_ptr);
  assign fetch   = avail && !buf_full;
  assign pop     = m_valid && m_ready;
  assign rd_addr = rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (fetch) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  rd_out_buf #(
    .DWIDTH (DWIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch),
    .push_data (rd_data),
    .pop       (pop),
    .full      (buf_full),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .count     (occ)
  );

`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0] ram_words;

  assign ram_words = wr_ptr - rd_ptr;
  assign rd_level  = {1'b0, ram_words} + {{AW{1'b0}}, occ};
`else
  logic occ_unused;

  assign occ_unused = ^occ;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed scenarios plus a randomized run against a word-queue model.
module tb_fifo_rd_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW+1:0] rd_level;
`endif

  logic [DW-1:0] mem [DEPTH];
  assign rd_data = mem[rd_addr];

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  int written = 0;
  int popped  = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DWIDTH (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level (rd_level)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ram_cnt();
    logic [AW:0] d;
    d = wr_ptr - rd_ptr;
    return int'(d);
  endfunction

  task automatic write_word(input logic [DW-1:0] data);
    mem[wr_ptr[AW-1:0]] = data;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(data);
    written++;
  endtask

  // Advance one clock; outside reset, score pops and the reader-held word count.
  task automatic tick();
    logic          pre_rst;
    logic          pre_pop;
    logic          pre_hold;
    logic          pre_avail;
    logic [DW-1:0] pre_data;
    logic [AW:0]   exp_rd;
    int            pre_held;
    int            held;
    pre_rst   = rst_n;
    pre_pop   = m_valid && m_ready;
    pre_hold  = m_valid && !m_ready;
    pre_data  = m_data;
    pre_avail = (wr_ptr != rd_ptr);
    pre_held  = written - popped - ram_cnt();
    exp_rd    = rd_ptr + ((pre_avail && pre_held < 2) ? 1'b1 : 1'b0);
    @(posedge clk);
    #1;
    if (pre_rst) begin
      if (pre_pop) begin
        check("pop_has_word", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check("pop_data", 64'(pre_data), 64'(exp_q.pop_front()));
          popped++;
        end
      end
      check("rd_ptr_step", 64'(rd_ptr), 64'(exp_rd));
      if (pre_hold) begin
        check("hold_data", 64'(m_data), 64'(pre_data));
      end
      held = written - popped - ram_cnt();
      check("held_range", 64'(held >= 0 && held <= 2), 64'd1);
      check("valid_vs_held", 64'(m_valid), 64'(held > 0));
`ifdef FIFO_RD_LEVEL_EN
      check("rd_level", 64'(rd_level), 64'(written - popped));
`endif
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = '0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    written = 0;
    popped  = 0;
  endtask

  initial begin
    int idx;
    int cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset and idle
    do_reset();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    for (int k = 0; k < 5; k++) tick();
    check("idle_valid", 64'(m_valid), 64'd0);
    check("idle_rd_ptr", 64'(rd_ptr), 64'd0);
    check("idle_data", 64'(m_data), 64'd0);

    // Burst of four at full rate
    for (int i = 0; i < 4; i++) write_word(8'hA0 + 8'(i));
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_valid", 64'(m_valid), 64'd1);
      check("burst_data", 64'(m_data), 64'(8'hA0 + k));
    end
    check("burst_rd_ptr", 64'(rd_ptr), 64'd4);
    tick();
    check("burst_drained", 64'(m_valid), 64'd0);

    // Backpressure fills the buffer
    do_reset();
    for (int i = 0; i < 4; i++) write_word(8'hA0 + 8'(i));
    tick();
    tick();
    check("bp_rd_ptr", 64'(rd_ptr), 64'd2);
    check("bp_data", 64'(m_data), 64'hA0);
`ifdef FIFO_RD_LEVEL_EN
    check("bp_level", 64'(rd_level), 64'd4);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_ptr", 64'(rd_ptr), 64'd2);
      check("bp_hold_data", 64'(m_data), 64'hA0);
    end
    for (int k = 0; k < 16; k++) begin
      m_ready = (k % 2 == 0);
      tick();
    end
    check("toggle_popped", 64'(popped), 64'd4);
    check("toggle_rd_ptr", 64'(rd_ptr), 64'd4);
    check("toggle_empty", 64'(m_valid), 64'd0);

    // Randomized wrap run with data = index
    do_reset();
    idx = 0;
    cyc = 0;
    while (popped < 20 && cyc < 1000) begin
      if (idx < 20 && ram_cnt() < DEPTH && $urandom_range(0, 3) != 0) begin
        write_word(8'(idx));
        idx++;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    check("wrap_popped", 64'(popped), 64'd20);
    check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wrap_rd_ptr", 64'(rd_ptr), 64'd4);

    // Reset while holding two words
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(8'h50 + 8'(i));
    tick();
    tick();
    check("two_valid", 64'(m_valid), 64'd1);
    check("two_rd_ptr", 64'(rd_ptr), 64'd6);
    check("two_data", 64'(m_data), 64'h50);
    rst_n  = 1'b0;
    wr_ptr = '0;
    tick();
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_rd_ptr", 64'(rd_ptr), 64'd0);
    check("mid_rst_data", 64'(m_data), 64'd0);
`ifdef FIFO_RD_LEVEL_EN
    check("mid_rst_level", 64'(rd_level), 64'd0);
`endif
    rst_n = 1'b1;
    exp_q.delete();
    written = 0;
    popped  = 0;
    tick();
    check("post_rst_valid", 64'(m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
